// File: rtl/bbqm_door_sensor_if.sv
// bbqm_door_sensor_if: signal bundle between the door photocells / queue
// counter and the door sensor front-end.
// The master side drives the raw beams and the counter flags; the slave side
// (the door sensor) returns the passage pulses and status.
// With BBQM_DOOR_STATS_EN defined the bundle also carries total_in/total_out.
interface bbqm_door_sensor_if;
   logic       sens_a;
   logic       sens_b;
   logic       full;
   logic       empty;
   logic       inc_pulse;
   logic       dec_pulse;
   logic       reject;
   logic       abort;
   logic       busy;
`ifdef BBQM_DOOR_STATS_EN
   logic [7:0] total_in;
   logic [7:0] total_out;

   modport master (
      output sens_a, sens_b, full, empty,
      input  inc_pulse, dec_pulse, reject, abort, busy, total_in, total_out
   );

   modport slave (
      input  sens_a, sens_b, full, empty,
      output inc_pulse, dec_pulse, reject, abort, busy, total_in, total_out
   );
`else
   modport master (
      output sens_a, sens_b, full, empty,
      input  inc_pulse, dec_pulse, reject, abort, busy
   );

   modport slave (
      input  sens_a, sens_b, full, empty,
      output inc_pulse, dec_pulse, reject, abort, busy
   );
`endif
endinterface

// File: rtl/bbqm_door_sensor.sv
// bbqm_door_sensor: door photocell front-end for the bank queue manager.
// Beam A is on the outside edge of the doorway, beam B on the inside edge.
// Both beams are synchronised (two flops), debounced, and the order in which
// they break and release is decoded into single-cycle enter/leave pulses.
// Completed passages are gated by the queue counter's full/empty flags.
// Optional feature macro: BBQM_DOOR_STATS_EN adds saturating 8-bit
// total_in/total_out tallies of issued inc/dec pulses.
//
// state | meaning
// IDLE  | doorway clear, waiting for a beam to break
// E_A   | entering: outer beam only
// E_AB  | entering: both beams
// E_B   | entering: inner beam only
// L_B   | leaving: inner beam only
// L_BA  | leaving: both beams
// L_A   | leaving: outer beam only
// CLEAR | passage abandoned, waiting for both beams to release
module bbqm_door_sensor #(
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned TIMEOUT_CYCLES  = 50_000_000
) (
   input logic              clk,
   input logic              reset,
   bbqm_door_sensor_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      E_A   = 3'd1,
      E_AB  = 3'd2,
      E_B   = 3'd3,
      L_B   = 3'd4,
      L_BA  = 3'd5,
      L_A   = 3'd6,
      CLEAR = 3'd7
   } state_t;

   // Counter compare values: a counter that has reached *_LAST is on its
   // final cycle, so the action lands exactly DEBOUNCE/TIMEOUT cycles in.
   localparam logic [7:0]  DB_LAST = 8'(DEBOUNCE_CYCLES - 1);
   localparam logic [25:0] TO_LAST = 26'(TIMEOUT_CYCLES - 1);

   logic        a_s1, a_s2, b_s1, b_s2;
   logic        a_db, b_db;
   logic [7:0]  a_cnt, b_cnt;
   logic [1:0]  pair;

   state_t      state, state_next;
   logic [25:0] tcnt;
   logic        in_passage;
   logic        timeout;

   logic        inc_d, dec_d, reject_d, abort_d;
   logic        inc_q, dec_q, reject_q, abort_q;

   // two-flop synchronisers for the asynchronous beam inputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_s1 <= 1'b0;
         a_s2 <= 1'b0;
         b_s1 <= 1'b0;
         b_s2 <= 1'b0;
      end else begin
         a_s1 <= bus.sens_a;
         a_s2 <= a_s1;
         b_s1 <= bus.sens_b;
         b_s2 <= b_s1;
      end
   end

   // debounce beam A: flip only after DEBOUNCE_CYCLES consecutive differing samples
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_cnt <= '0;
         a_db  <= 1'b0;
      end else if (a_s2 == a_db) begin
         a_cnt <= '0;
      end else if (a_cnt == DB_LAST) begin
         a_db  <= a_s2;
         a_cnt <= '0;
      end else begin
         a_cnt <= a_cnt + 8'd1;
      end
   end

   // debounce beam B: same filter as beam A
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         b_cnt <= '0;
         b_db  <= 1'b0;
      end else if (b_s2 == b_db) begin
         b_cnt <= '0;
      end else if (b_cnt == DB_LAST) begin
         b_db  <= b_s2;
         b_cnt <= '0;
      end else begin
         b_cnt <= b_cnt + 8'd1;
      end
   end

   assign pair       = {a_db, b_db};
   assign in_passage = (state != IDLE) && (state != CLEAR);
   assign timeout    = in_passage && (tcnt == TO_LAST);

   // FSM state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // dwell timer: restarts on every state change, idle outside passage states
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tcnt <= '0;
      end else if (!in_passage || (state_next != state)) begin
         tcnt <= '0;
      end else begin
         tcnt <= tcnt + 26'd1;
      end
   end

   // next-state decode on the debounced pair; a timeout overrides any beam change
   always_comb begin
      state_next = state;
      if (timeout) begin
         state_next = CLEAR;
      end else begin
         unique case (state)
            IDLE: begin
               case (pair)
                  2'b10:   state_next = E_A;
                  2'b01:   state_next = L_B;
                  2'b11:   state_next = CLEAR;
                  default: state_next = IDLE;
               endcase
            end
            E_A: begin
               case (pair)
                  2'b11:   state_next = E_AB;
                  2'b00:   state_next = IDLE;
                  2'b01:   state_next = CLEAR;
                  default: state_next = E_A;
               endcase
            end
            E_AB: begin
               case (pair)
                  2'b01:   state_next = E_B;
                  2'b10:   state_next = E_A;
                  2'b00:   state_next = CLEAR;
                  default: state_next = E_AB;
               endcase
            end
            E_B: begin
               case (pair)
                  2'b00:   state_next = IDLE;
                  2'b11:   state_next = E_AB;
                  2'b10:   state_next = CLEAR;
                  default: state_next = E_B;
               endcase
            end
            L_B: begin
               case (pair)
                  2'b11:   state_next = L_BA;
                  2'b00:   state_next = IDLE;
                  2'b10:   state_next = CLEAR;
                  default: state_next = L_B;
               endcase
            end
            L_BA: begin
               case (pair)
                  2'b10:   state_next = L_A;
                  2'b01:   state_next = L_B;
                  2'b00:   state_next = CLEAR;
                  default: state_next = L_BA;
               endcase
            end
            L_A: begin
               case (pair)
                  2'b00:   state_next = IDLE;
                  2'b11:   state_next = L_BA;
                  2'b01:   state_next = CLEAR;
                  default: state_next = L_A;
               endcase
            end
            CLEAR: begin
               if (pair == 2'b00) state_next = IDLE;
            end
            default: state_next = IDLE;
         endcase
      end
   end

   // pulse decode from the transition being taken; full/empty sampled here
   always_comb begin
      inc_d    = 1'b0;
      dec_d    = 1'b0;
      reject_d = 1'b0;
      abort_d  = 1'b0;
      if ((state == E_B) && (state_next == IDLE)) begin
         if (bus.full) reject_d = 1'b1;
         else          inc_d    = 1'b1;
      end else if ((state == L_A) && (state_next == IDLE)) begin
         if (bus.empty) reject_d = 1'b1;
         else           dec_d    = 1'b1;
      end else if ((state != CLEAR) && (state_next == CLEAR)) begin
         abort_d = 1'b1;
      end
   end

   // registered pulse outputs, glitch-free toward the queue counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         inc_q    <= 1'b0;
         dec_q    <= 1'b0;
         reject_q <= 1'b0;
         abort_q  <= 1'b0;
      end else begin
         inc_q    <= inc_d;
         dec_q    <= dec_d;
         reject_q <= reject_d;
         abort_q  <= abort_d;
      end
   end

   assign bus.inc_pulse = inc_q;
   assign bus.dec_pulse = dec_q;
   assign bus.reject    = reject_q;
   assign bus.abort     = abort_q;
   assign bus.busy      = (state != IDLE);

`ifdef BBQM_DOOR_STATS_EN
   logic [7:0] total_in_q;
   logic [7:0] total_out_q;

   // saturating tallies of issued inc/dec pulses (rejects not counted)
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         total_in_q  <= '0;
         total_out_q <= '0;
      end else begin
         if (inc_d && (total_in_q != 8'hFF))  total_in_q  <= total_in_q + 8'd1;
         if (dec_d && (total_out_q != 8'hFF)) total_out_q <= total_out_q + 8'd1;
      end
   end

   assign bus.total_in  = total_in_q;
   assign bus.total_out = total_out_q;
`endif

endmodule
